// File: rtl/cam_ctrl.sv
// cam_ctrl: request sequencer in front of a 14-entry CAM with no valid bits
// and no memory reset. Clears the CAM after reset, keeps a per-slot valid
// bitmap, allocates free slots and masks hits on stale entries. Every output
// is a flop whose D input is decoded from the next state, so the pins follow
// the current state with no combinational path from req_* or rsp_ready.
module cam_ctrl #(
    parameter int NB_MEM    = 14,
    parameter int SIZE_ADDR = 4,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [DATA_W-1:0]    req_key,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic                 rsp_full,
    output logic [SIZE_ADDR:0]   rsp_idx,
    output logic [SIZE_ADDR-1:0] occupancy,
    output logic                 cam_enable,
    output logic                 cam_write,
    output logic [SIZE_ADDR:0]   cam_addr,
    output logic [DATA_W-1:0]    cam_data,
    input  logic [SIZE_ADDR:0]   cam_out,
    input  logic                 cam_found
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_LOOK  = 3'd2,
        S_EVAL  = 3'd3,
        S_WRITE = 3'd4,
        S_FLUSH = 3'd5,
        S_RESP  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_FLUSH  = 2'b11
    } op_e;

    localparam logic [SIZE_ADDR-1:0] LAST_SLOT = SIZE_ADDR'(NB_MEM - 1);
    localparam logic [SIZE_ADDR-1:0] FULL_CNT  = SIZE_ADDR'(NB_MEM);
    localparam logic [SIZE_ADDR:0]   NB_MEM_A  = (SIZE_ADDR + 1)'(NB_MEM);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [SIZE_ADDR-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]      key_q, key_d;
    logic [NB_MEM-1:0]      valid_q, valid_d;
    logic [SIZE_ADDR-1:0]   occ_q;
    logic [SIZE_ADDR-1:0]   target_q, target_d;
    logic                   hit_q, hit_d;
    logic                   full_q, full_d;
    logic [SIZE_ADDR:0]     idx_q, idx_d;

    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   cam_en_q, cam_en_d;
    logic                   cam_wr_q, cam_wr_d;
    logic [SIZE_ADDR:0]     cam_addr_q, cam_addr_d;
    logic [DATA_W-1:0]      cam_data_q, cam_data_d;

    logic [SIZE_ADDR-1:0]   free_slot;
    logic                   free_ok;
    logic [SIZE_ADDR-1:0]   slot_in;
    logic                   in_range;
    logic                   hv;
    logic                   stale;

    function automatic logic [SIZE_ADDR-1:0] popcount(input logic [NB_MEM-1:0] v);
        logic [SIZE_ADDR-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NB_MEM; i++) c = c + SIZE_ADDR'(v[i]);
        return c;
    endfunction

    // Lowest slot whose valid bit is clear
    always_comb begin
        free_slot = '0;
        free_ok   = 1'b0;
        for (int unsigned i = 0; i < NB_MEM; i++) begin
            if (!valid_q[i] && !free_ok) begin
                free_slot = SIZE_ADDR'(i);
                free_ok   = 1'b1;
            end
        end
    end

    // Qualify the CAM result with the valid bitmap
    always_comb begin
        slot_in  = cam_out[SIZE_ADDR-1:0];
        in_range = cam_out < NB_MEM_A;
        hv       = cam_found && in_range && valid_q[slot_in];
        stale    = cam_found && in_range && !valid_q[slot_in];
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            op_q        <= OP_LOOKUP;
            cnt_q       <= '0;
            key_q       <= '0;
            valid_q     <= '0;
            occ_q       <= '0;
            target_q    <= '0;
            hit_q       <= 1'b0;
            full_q      <= 1'b0;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            cam_en_q    <= 1'b0;
            cam_wr_q    <= 1'b0;
            cam_addr_q  <= '0;
            cam_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            valid_q     <= valid_d;
            occ_q       <= popcount(valid_d);
            target_q    <= target_d;
            hit_q       <= hit_d;
            full_q      <= full_d;
            idx_q       <= idx_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            cam_en_q    <= cam_en_d;
            cam_wr_q    <= cam_wr_d;
            cam_addr_q  <= cam_addr_d;
            cam_data_q  <= cam_data_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        valid_d  = valid_q;
        target_d = target_q;
        hit_d    = hit_q;
        full_d   = full_q;
        idx_d    = idx_q;
        unique case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_SLOT) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d    = op_e'(req_op);
                    key_d   = req_key;
                    state_d = (op_e'(req_op) == OP_FLUSH) ? S_FLUSH : S_LOOK;
                end
            end
            S_LOOK: state_d = S_EVAL;
            S_EVAL: begin
                hit_d   = hv;
                full_d  = 1'b0;
                idx_d   = hv ? {1'b0, slot_in} : '0;
                state_d = S_RESP;
                if (op_q == OP_DELETE && hv) valid_d[slot_in] = 1'b0;
                if (op_q == OP_INSERT && !hv) begin
                    if (stale) begin
                        target_d = slot_in;
                        state_d  = S_WRITE;
                    end else if (occ_q != FULL_CNT && free_ok) begin
                        target_d = free_slot;
                        state_d  = S_WRITE;
                    end else begin
                        full_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                valid_d[target_q] = 1'b1;
                hit_d   = 1'b0;
                full_d  = 1'b0;
                idx_d   = {1'b0, target_q};
                state_d = S_RESP;
            end
            S_FLUSH: begin
                valid_d = '0;
                hit_d   = 1'b0;
                full_d  = 1'b0;
                idx_d   = '0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready && rsp_valid_q) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Output decode of the next state; the init write tracks the current count
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        cam_en_d    = (state_d == S_LOOK);
        cam_wr_d    = (state_q == S_INIT) || (state_d == S_WRITE);
        cam_addr_d  = '0;
        cam_data_d  = '0;
        if (state_q == S_INIT) begin
            cam_addr_d = {1'b0, cnt_q};
        end else if (state_d == S_WRITE) begin
            cam_addr_d = {1'b0, target_d};
            cam_data_d = key_d;
        end else if (state_d == S_LOOK) begin
            cam_data_d = key_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = hit_q;
    assign rsp_full   = full_q;
    assign rsp_idx    = idx_q;
    assign occupancy  = occ_q;
    assign cam_enable = cam_en_q;
    assign cam_write  = cam_wr_q;
    assign cam_addr   = cam_addr_q;
    assign cam_data   = cam_data_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: drives cam_ctrl against a behavioural CAM and checks every
// response against a table-level reference model of the slot contents.
module tb_cam_ctrl;

    localparam int NB = 14;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_key;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_hit;
    logic       rsp_full;
    logic [4:0] rsp_idx;
    logic [3:0] occupancy;
    logic       cam_enable;
    logic       cam_write;
    logic [4:0] cam_addr;
    logic [7:0] cam_data;
    logic [4:0] cam_out;
    logic       cam_found;

    always #5 clk = ~clk;

    cam_ctrl #(.NB_MEM(14), .SIZE_ADDR(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_full(rsp_full),
        .rsp_idx(rsp_idx), .occupancy(occupancy),
        .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr), .cam_data(cam_data),
        .cam_out(cam_out), .cam_found(cam_found)
    );

    // Behavioural CAM: no reset, highest matching slot wins
    logic [7:0] cmem [NB];
    int         wr_cnt = 0;

    function automatic logic [5:0] cam_match(input logic [7:0] k);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) if (cmem[i] == k) r = {1'b1, 5'(i)};
        return r;
    endfunction

    always @(posedge clk) begin
        if (cam_write && cam_addr < 5'(NB)) cmem[cam_addr[3:0]] <= cam_data;
        if (cam_write) wr_cnt <= wr_cnt + 1;
        if (cam_enable) {cam_found, cam_out} <= cam_match(cam_data);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: what each slot holds and whether it is live
    logic [7:0] rcam   [NB];
    bit         rvalid [NB];

    function automatic int ref_occ();
        int c = 0;
        for (int i = 0; i < NB; i++) if (rvalid[i]) c++;
        return c;
    endfunction

    function automatic bit key_live(input logic [7:0] k);
        for (int i = 0; i < NB; i++) if (rvalid[i] && rcam[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < NB; i++) begin
            rcam[i]   = 8'h00;
            rvalid[i] = 1'b0;
        end
    endtask

    task automatic model_op(input logic [1:0] op, input logic [7:0] key,
                            output bit hit, output bit full, output int idx,
                            output int lat, output int wr);
        int v, hi, cnt, fr, s;
        hit = 0; full = 0; idx = 0; lat = 3; wr = 0;
        if (op == 2'b11) begin
            for (int i = 0; i < NB; i++) rvalid[i] = 1'b0;
            lat = 2;
            return;
        end
        v = -1; hi = -1; cnt = 0; fr = -1;
        for (int i = 0; i < NB; i++) begin
            if (rvalid[i] && rcam[i] == key) v = i;
            if (rcam[i] == key) hi = i;
            if (rvalid[i]) cnt++;
            else if (fr < 0) fr = i;
        end
        hit = (v >= 0);
        if (hit) idx = v;
        if (op == 2'b10 && hit) rvalid[v] = 1'b0;
        if (op == 2'b01 && !hit) begin
            s = -1;
            if (hi >= 0) s = hi;
            else if (cnt < NB) s = fr;
            else full = 1;
            if (s >= 0) begin
                rcam[s] = key; rvalid[s] = 1'b1;
                idx = s; lat = 4; wr = 1;
            end
        end
    endtask

    task automatic do_req(input string tag, input logic [1:0] op, input logic [7:0] key,
                          input int hold);
        bit e_hit, e_full;
        int e_idx, e_lat, e_wr, waited, lat, w0;
        model_op(op, key, e_hit, e_full, e_idx, e_lat, e_wr);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_key = key;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 0; w0 = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0;
                w0 = wr_cnt;
            end
            if (rsp_valid) break;
        end
        check({tag, "_lat"},  32'(lat), 32'(e_lat));
        check({tag, "_rsp"},  {27'd0, rsp_hit, rsp_full, rsp_idx[2:0]} | {24'd0, 3'd0, rsp_idx[4:3], 3'd0} << 0,
                              {27'd0, e_hit, e_full, 3'(e_idx)} | {24'd0, 3'd0, 2'(e_idx >> 3), 3'd0});
        check({tag, "_idx"},  32'(rsp_idx), 32'(e_idx));
        check({tag, "_wr"},   32'(wr_cnt - w0), 32'(e_wr));
        check({tag, "_occ"},  32'(occupancy), 32'(ref_occ()));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("%s_hold%0d", tag, h),
                  {22'd0, rsp_valid, rsp_hit, rsp_full, rsp_idx, req_ready, cam_enable, cam_write},
                  {22'd0, 1'b1, e_hit, e_full, 5'(e_idx), 3'b000});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    // Reset release sequence: 14 zeroing writes, then ready
    task automatic init_check(input string tag);
        #1;
        check({tag, "_rdy0"}, 32'(req_ready), 32'd0);
        for (int k = 1; k <= NB; k++) begin
            @(negedge clk);
            check($sformatf("%s_init%0d", tag, k),
                  {17'd0, cam_write, cam_addr, cam_data, req_ready},
                  {17'd0, 1'b1, 5'(k - 1), 8'h00, 1'(k == NB)});
        end
        check({tag, "_occ0"}, 32'(occupancy), 32'd0);
        ref_reset();
    endtask

    function automatic logic [7:0] new_key();
        logic [7:0] k;
        k = 8'($urandom);
        while (key_live(k)) k = 8'($urandom);
        return k;
    endfunction

    initial begin
        logic [7:0] k;
        int         waited;
        for (int i = 0; i < NB; i++) cmem[i] = 8'($urandom);
        cam_out = '0; cam_found = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_key = '0; rsp_ready = 1'b0;
        #1;
        check("reset_out",
              {14'd0, req_ready, rsp_valid, rsp_hit, rsp_full, rsp_idx, occupancy, cam_enable, cam_write, cam_addr},
              32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        init_check("t1");

        // T2: first insert lands in slot 0, repeat is a duplicate
        do_req("t2_ins", 2'b01, 8'hA5, 0);
        do_req("t2_dup", 2'b01, 8'hA5, 0);

        // T3: zeroed slots are stale, key 0x00 reuses the highest one
        do_req("t3_look0", 2'b00, 8'h00, 0);
        do_req("t3_ins0",  2'b01, 8'h00, 0);
        check("t3_slot13", 32'(rvalid[13] && rcam[13] == 8'h00), 32'd1);

        // T4: fill, overflow, delete slot 5
        while (ref_occ() < NB) do_req("t4_fill", 2'b01, new_key(), 0);
        do_req("t4_full", 2'b01, new_key(), 0);
        do_req("t4_del5", 2'b10, rcam[5], 0);
        check("t4_occ13", 32'(occupancy), 32'd13);

        // T5: back-pressure, then flush
        k = rcam[0];
        do_req("t5_hold", 2'b00, k, 5);
        do_req("t5_flush", 2'b11, 8'h00, 0);
        do_req("t5_look", 2'b00, k, 0);

        // Random traffic over a small key pool to exercise stale reuse and full
        for (int n = 0; n < 80; n++) begin
            int r;
            logic [1:0] op;
            r  = int'($urandom_range(0, 99));
            op = (r < 50) ? 2'b01 : (r < 75) ? 2'b00 : (r < 96) ? 2'b10 : 2'b11;
            do_req($sformatf("rnd%0d", n), op, 8'h10 + 8'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)));
        end

        // T6: reset asserted while the insert write is on the pins
        do_req("t6_flush", 2'b11, 8'h00, 0);
        k = new_key();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_key = k;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        waited = 0;
        while (waited < 10) begin
            @(negedge clk);
            req_valid = 1'b0;
            waited++;
            if (cam_write) break;
        end
        check("t6_write_seen", 32'(cam_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_out",
              {14'd0, req_ready, rsp_valid, rsp_hit, rsp_full, rsp_idx, occupancy, cam_enable, cam_write, cam_addr},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        init_check("t6");
        do_req("t6_look", 2'b00, k, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
